// File: rtl/fetch_sequencer.sv
// Next-PC selection and IF/ID, ID/EX stall/flush control for the IF stage,
// with deferred redirects across instruction-memory misses and debug counters.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_cur,
    input  logic        imem_busywait,
    input  logic        hazard_stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc_next,
    output logic        pc_hold,
    output logic        imem_read,
    output logic        fetch_valid,
    output logic        ifid_stall,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        misalign_err,
    output logic [15:0] stall_cnt,
    output logic [15:0] redirect_cnt
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2,
        PEND = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    state_t      cur_state;
    logic [31:0] pend_target;
    logic [31:0] pend_nxt;
    logic [31:0] tgt;
    logic        redirect_apply;

    // The PC register resets to RESET_PC; it must be a legal word address.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_check
        $error("fetch_sequencer: RESET_PC must be word aligned");
    end

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign tgt = {redirect_target[31:2], 2'b00};

    // Reset forces BOOT outputs in the same cycle, whatever state is held.
    assign cur_state = rst ? BOOT : state;

    always_comb begin
        pc_next        = pc_cur;
        pc_hold        = 1'b1;
        imem_read      = 1'b1;
        ifid_stall     = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        state_nxt      = cur_state;
        pend_nxt       = pend_target;
        redirect_apply = 1'b0;

        case (cur_state)
            BOOT: begin
                imem_read = 1'b0;
                state_nxt = RUN;
            end
            RUN, WAIT: begin
                if (redirect_valid && !imem_busywait) begin
                    pc_next        = tgt;
                    pc_hold        = 1'b0;
                    ifid_flush     = 1'b1;
                    idex_flush     = 1'b1;
                    state_nxt      = RUN;
                    redirect_apply = 1'b1;
                end else if (redirect_valid) begin
                    pend_nxt   = tgt;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    state_nxt  = PEND;
                end else if (imem_busywait) begin
                    ifid_stall = 1'b1;
                    state_nxt  = WAIT;
                end else if (hazard_stall) begin
                    ifid_stall = 1'b1;
                    state_nxt  = RUN;
                end else begin
                    pc_next   = pc_cur + 32'd4;
                    pc_hold   = 1'b0;
                    state_nxt = RUN;
                end
            end
            default: begin
                // PEND: a fresh redirect replaces the latched one (newest wins).
                ifid_flush = 1'b1;
                if (redirect_valid) begin
                    pend_nxt = tgt;
                end
                if (!imem_busywait) begin
                    pc_next        = redirect_valid ? tgt : pend_target;
                    pc_hold        = 1'b0;
                    state_nxt      = RUN;
                    redirect_apply = 1'b1;
                end
            end
        endcase

        fetch_valid = ((cur_state == RUN) || (cur_state == WAIT)) &&
                      !imem_busywait && !ifid_flush;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= BOOT;
            pend_target  <= 32'd0;
            stall_cnt    <= 16'd0;
            redirect_cnt <= 16'd0;
            misalign_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            pend_target <= pend_nxt;
            if (pc_hold && (state != BOOT)) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (redirect_apply) begin
                redirect_cnt <= sat_inc(redirect_cnt);
            end
            if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
                misalign_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Vector table and hand-written sequences for fetch_sequencer; expectations
// are queued by the driver and compared by a monitor on the falling edge.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_cur;
    logic        imem_busywait;
    logic        hazard_stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc_next;
    logic        pc_hold;
    logic        imem_read;
    logic        fetch_valid;
    logic        ifid_stall;
    logic        ifid_flush;
    logic        idex_flush;
    logic        misalign_err;
    logic [15:0] stall_cnt;
    logic [15:0] redirect_cnt;

    fetch_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_cur          (pc_cur),
        .imem_busywait   (imem_busywait),
        .hazard_stall    (hazard_stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc_next         (pc_next),
        .pc_hold         (pc_hold),
        .imem_read       (imem_read),
        .fetch_valid     (fetch_valid),
        .ifid_stall      (ifid_stall),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .misalign_err    (misalign_err),
        .stall_cnt       (stall_cnt),
        .redirect_cnt    (redirect_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic        rst;
        logic [31:0] pc;
        logic        busy;
        logic        hz;
        logic        rv;
        logic [31:0] rt;
        logic [31:0] e_next;
        logic        e_hold;
        logic        e_read;
        logic        e_fv;
        logic        e_stall;
        logic        e_iff;
        logic        e_idf;
        logic        chk_cnt;
        logic [15:0] e_scnt;
        logic [15:0] e_rcnt;
        logic        e_mis;
    } vec_t;

    vec_t sb[$];
    vec_t tbl[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic vec_t mk(
        input string nm, input logic r, input logic [31:0] pc, input logic busy,
        input logic hz, input logic rv, input logic [31:0] rt,
        input logic [31:0] e_next, input logic e_hold, input logic e_read,
        input logic e_fv, input logic e_stall, input logic e_iff, input logic e_idf,
        input logic chk_cnt, input logic [15:0] e_scnt, input logic [15:0] e_rcnt,
        input logic e_mis);
        vec_t v;
        v.nm = nm; v.rst = r; v.pc = pc; v.busy = busy; v.hz = hz; v.rv = rv;
        v.rt = rt; v.e_next = e_next; v.e_hold = e_hold; v.e_read = e_read;
        v.e_fv = e_fv; v.e_stall = e_stall; v.e_iff = e_iff; v.e_idf = e_idf;
        v.chk_cnt = chk_cnt; v.e_scnt = e_scnt; v.e_rcnt = e_rcnt; v.e_mis = e_mis;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic apply(input vec_t v);
        @(posedge clk);
        #1;
        rst             = v.rst;
        pc_cur          = v.pc;
        imem_busywait   = v.busy;
        hazard_stall    = v.hz;
        redirect_valid  = v.rv;
        redirect_target = v.rt;
        sb.push_back(v);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t v;
            v = sb.pop_front();
            check({v.nm, ".pc_next"},     pc_next,             v.e_next);
            check({v.nm, ".pc_hold"},     {31'd0, pc_hold},    {31'd0, v.e_hold});
            check({v.nm, ".imem_read"},   {31'd0, imem_read},  {31'd0, v.e_read});
            check({v.nm, ".fetch_valid"}, {31'd0, fetch_valid},{31'd0, v.e_fv});
            check({v.nm, ".ifid_stall"},  {31'd0, ifid_stall}, {31'd0, v.e_stall});
            check({v.nm, ".ifid_flush"},  {31'd0, ifid_flush}, {31'd0, v.e_iff});
            check({v.nm, ".idex_flush"},  {31'd0, idex_flush}, {31'd0, v.e_idf});
            if (v.chk_cnt) begin
                check({v.nm, ".stall_cnt"},    {16'd0, stall_cnt},    {16'd0, v.e_scnt});
                check({v.nm, ".redirect_cnt"}, {16'd0, redirect_cnt}, {16'd0, v.e_rcnt});
                check({v.nm, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, v.e_mis});
            end
        end
    end

    initial begin
        rst             = 1'b1;
        pc_cur          = 32'd0;
        imem_busywait   = 1'b0;
        hazard_stall    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;

        //                 name        rst pc            bsy hz rv rt            next          hld rd fv st if id  chk scnt rcnt mis
        tbl.push_back(mk("rst0",       1, 32'h0,        0, 0, 0, 32'h0,     32'h0,        1, 0, 0, 0, 0, 0,  0,  0,  0, 0));
        tbl.push_back(mk("rst1",       1, 32'h0,        0, 0, 0, 32'h0,     32'h0,        1, 0, 0, 0, 0, 0,  1,  0,  0, 0));
        tbl.push_back(mk("boot",       0, 32'h0,        0, 0, 0, 32'h0,     32'h0,        1, 0, 0, 0, 0, 0,  1,  0,  0, 0));
        tbl.push_back(mk("seq4",       0, 32'h0,        0, 0, 0, 32'h0,     32'h4,        0, 1, 1, 0, 0, 0,  1,  0,  0, 0));
        tbl.push_back(mk("seq8",       0, 32'h4,        0, 0, 0, 32'h0,     32'h8,        0, 1, 1, 0, 0, 0,  0,  0,  0, 0));
        tbl.push_back(mk("seq12",      0, 32'h8,        0, 0, 0, 32'h0,     32'hC,        0, 1, 1, 0, 0, 0,  0,  0,  0, 0));
        tbl.push_back(mk("miss1",      0, 32'h10,       1, 0, 0, 32'h0,     32'h10,       1, 1, 0, 1, 0, 0,  1,  0,  0, 0));
        tbl.push_back(mk("miss2",      0, 32'h10,       1, 0, 0, 32'h0,     32'h10,       1, 1, 0, 1, 0, 0,  1,  1,  0, 0));
        tbl.push_back(mk("miss3",      0, 32'h10,       1, 0, 0, 32'h0,     32'h10,       1, 1, 0, 1, 0, 0,  1,  2,  0, 0));
        tbl.push_back(mk("miss_end",   0, 32'h10,       0, 0, 0, 32'h0,     32'h14,       0, 1, 1, 0, 0, 0,  1,  3,  0, 0));
        tbl.push_back(mk("redir_rdy",  0, 32'h14,       0, 1, 1, 32'h200,   32'h200,      0, 1, 0, 0, 1, 1,  1,  3,  0, 0));
        tbl.push_back(mk("post_redir", 0, 32'h200,      0, 0, 0, 32'h0,     32'h204,      0, 1, 1, 0, 0, 0,  1,  3,  1, 0));
        tbl.push_back(mk("hazard",     0, 32'h204,      0, 1, 0, 32'h0,     32'h204,      1, 1, 1, 1, 0, 0,  1,  3,  1, 0));
        tbl.push_back(mk("misalign",   0, 32'h204,      0, 0, 1, 32'h1003,  32'h1000,     0, 1, 0, 0, 1, 1,  1,  4,  1, 0));
        tbl.push_back(mk("mis_sticky", 0, 32'h1000,     0, 0, 0, 32'h0,     32'h1004,     0, 1, 1, 0, 0, 0,  1,  4,  2, 1));
        tbl.push_back(mk("wrap",       0, 32'hFFFF_FFFC,0, 0, 0, 32'h0,     32'h0,        0, 1, 1, 0, 0, 0,  1,  4,  2, 1));
        tbl.push_back(mk("after_wrap", 0, 32'h0,        0, 0, 0, 32'h0,     32'h4,        0, 1, 1, 0, 0, 0,  1,  4,  2, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
        end

        // Redirect while memory is busy, overwritten two cycles later.
        apply(mk("pend_enter", 0, 32'h20,  1, 0, 1, 32'h400, 32'h20,  1, 1, 0, 0, 1, 1, 1, 4, 2, 1));
        apply(mk("pend_b1",    0, 32'h20,  1, 0, 0, 32'h0,   32'h20,  1, 1, 0, 0, 1, 0, 1, 5, 2, 1));
        apply(mk("pend_new",   0, 32'h20,  1, 1, 1, 32'h480, 32'h20,  1, 1, 0, 0, 1, 0, 1, 6, 2, 1));
        apply(mk("pend_b3",    0, 32'h20,  1, 1, 0, 32'h0,   32'h20,  1, 1, 0, 0, 1, 0, 1, 7, 2, 1));
        apply(mk("pend_b4",    0, 32'h20,  1, 0, 0, 32'h0,   32'h20,  1, 1, 0, 0, 1, 0, 1, 8, 2, 1));
        apply(mk("pend_apply", 0, 32'h20,  0, 1, 0, 32'h0,   32'h480, 0, 1, 0, 0, 1, 0, 1, 9, 2, 1));
        apply(mk("pend_after", 0, 32'h480, 0, 0, 0, 32'h0,   32'h484, 0, 1, 1, 0, 0, 0, 1, 9, 3, 1));

        // Reset while a redirect is pending: the latched target must vanish.
        apply(mk("rp_enter",   0, 32'h484, 1, 0, 1, 32'h800, 32'h484, 1, 1, 0, 0, 1, 1, 1, 9,  3, 1));
        apply(mk("rp_hold",    0, 32'h484, 1, 0, 0, 32'h0,   32'h484, 1, 1, 0, 0, 1, 0, 1, 10, 3, 1));
        apply(mk("rp_rst",     1, 32'h484, 1, 0, 0, 32'h0,   32'h484, 1, 0, 0, 0, 0, 0, 1, 11, 3, 1));
        apply(mk("rp_boot",    0, 32'h0,   0, 0, 0, 32'h0,   32'h0,   1, 0, 0, 0, 0, 0, 1, 0,  0, 0));
        apply(mk("rp_run",     0, 32'h0,   0, 0, 0, 32'h0,   32'h4,   0, 1, 1, 0, 0, 0, 1, 0,  0, 0));
        apply(mk("rp_run2",    0, 32'h4,   0, 0, 0, 32'h0,   32'h8,   0, 1, 1, 0, 0, 0, 1, 0,  0, 0));

        for (int k = 0; k < 10 && sb.size() != 0; k++) begin
            @(posedge clk);
        end
        check("scoreboard_drain", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
